// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM state encodings and
// the width of the optional stall counter.
package fifo_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      SEND_LO = 2'b01,
      SEND_HI = 2'b10
   } state_e;

   localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority picker: grants the first asserted request found when
// scanning from last_grant_i+1 upward, wrapping modulo NUM_REQ.
module rr_pick #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   last_grant_i,
   output logic [NUM_REQ-1:0] grant_oh_o,
   output logic [IDX_W-1:0]   grant_idx_o,
   output logic               any_o
);

   always_comb begin
      int idx;
      // NOTE: every output gets a default before the loop, so no path leaves a
      // value unassigned and no latch is inferred.
      idx         = 0;
      grant_oh_o  = '0;
      grant_idx_o = '0;
      any_o       = 1'b0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         idx = (int'(last_grant_i) + off) % NUM_REQ;
         if (!any_o && req_i[idx]) begin
            any_o           = 1'b1;
            grant_idx_o     = IDX_W'(idx);
            grant_oh_o[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin scheduler sharing one FIFO write port among NUM_REQ producers;
// each item is 1 or 2 words, low word first. Define FIFO_WR_ARB_STALL_CNT_EN to add stall_cnt.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int DSIZE   = 8
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*2*DSIZE-1:0] req_data,
   input  logic [NUM_REQ-1:0]       req_len2,
   output logic [NUM_REQ-1:0]       ack,
   input  logic                     wfull,
   output logic                     winc,
   output logic [DSIZE-1:0]         wdata,
   output logic                     busy
`ifdef FIFO_WR_ARB_STALL_CNT_EN
   ,
   output logic [STALL_CNT_W-1:0]   stall_cnt
`endif
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int WW    = 2 * DSIZE;

   state_e             state_q, state_d;
   logic [WW-1:0]      hold_data_q, hold_data_d;
   logic               hold_len2_q, hold_len2_d;
   logic [IDX_W-1:0]   last_grant_q, last_grant_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;

   logic [NUM_REQ-1:0] grant_oh;
   logic [IDX_W-1:0]   grant_idx;
   logic               grant_any;

   rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
      .req_i        (req),
      .last_grant_i (last_grant_q),
      .grant_oh_o   (grant_oh),
      .grant_idx_o  (grant_idx),
      .any_o        (grant_any)
   );

   always_comb begin
      state_d      = state_q;
      hold_data_d  = hold_data_q;
      hold_len2_d  = hold_len2_q;
      last_grant_d = last_grant_q;
      ack_d        = '0;
      case (state_q)
         IDLE: begin
            if (grant_any) begin
               hold_data_d  = req_data[int'(grant_idx)*WW +: WW];
               hold_len2_d  = req_len2[grant_idx];
               last_grant_d = grant_idx;
               ack_d        = grant_oh;
               state_d      = SEND_LO;
            end
         end
         SEND_LO: if (!wfull) state_d = hold_len2_q ? SEND_HI : IDLE;
         SEND_HI: if (!wfull) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the reset here is synchronous, sampled only on the clock edge; all
   // state updates use non-blocking assignments so every register sees the
   // pre-edge values of the others.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= IDLE;
         hold_data_q  <= '0;
         hold_len2_q  <= 1'b0;
         last_grant_q <= IDX_W'(NUM_REQ - 1);
         ack_q        <= '0;
      end else begin
         state_q      <= state_d;
         hold_data_q  <= hold_data_d;
         hold_len2_q  <= hold_len2_d;
         last_grant_q <= last_grant_d;
         ack_q        <= ack_d;
      end
   end

   // In IDLE the bus keeps showing the last word sent; the FIFO ignores it.
   always_comb begin
      case (state_q)
         SEND_LO: wdata = hold_data_q[DSIZE-1:0];
         SEND_HI: wdata = hold_data_q[WW-1:DSIZE];
         default: wdata = hold_len2_q ? hold_data_q[WW-1:DSIZE] : hold_data_q[DSIZE-1:0];
      endcase
   end

   assign winc = !RST && !wfull && (state_q != IDLE);
   assign busy = (state_q != IDLE);
   assign ack  = ack_q;

`ifdef FIFO_WR_ARB_STALL_CNT_EN
   logic [STALL_CNT_W-1:0] stall_cnt_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         stall_cnt_q <= '0;
      end else if ((state_q != IDLE) && wfull && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule
